plot_framebuffer: RTL
=====================

PLOT_FRAMEBUFFER -- requirements
Module: plot_framebuffer

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all logic rises on posedge clk.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port vga_x, input, 8, plot column.
REQ-004 SHALL have port vga_y, input, 7, plot row.
REQ-005 SHALL have port vga_colour, input, 3, plot colour.
REQ-006 SHALL have port vga_plot, input, 1, write strobe for one pixel per cycle.
REQ-007 SHALL have port clear, input, 1, request to fill the whole screen with clear_colour.
REQ-008 SHALL have port clear_colour, input, 3, fill colour, sampled with clear.
REQ-009 SHALL have port clear_busy, output, 1, high while a fill is in progress.
REQ-010 SHALL have port scan_en, input, 1, request for raster scan-out.
REQ-011 SHALL have port pix_valid, output, 1, scan-out pixel is valid.
REQ-012 SHALL have port pix_ready, input, 1, consumer accepts the pixel.
REQ-013 SHALL have ports pix_x (8), pix_y (7) and pix_colour (3), all outputs, giving the coordinates and colour of the scanned pixel.
REQ-014 SHALL have ports pix_sof, pix_eol and pix_eof, all outputs, 1 bit each, marking frame start (0,0), line end (x=159) and frame end (159,119).
REQ-015 SHALL have port plot_drop, output, 1, sticky flag set by an out-of-range plot.

Function
REQ-016 SHALL hold 160x120 pixels of 3 bits each, at address y*160+x (15 bits, range 0..19199).
REQ-017 SHALL implement the FSM states S_IDLE, S_SCAN and S_CLEAR.
REQ-018 SHALL move S_IDLE->S_CLEAR on clear=1; clear has priority over scan_en; clear is ignored outside S_IDLE.
REQ-019 SHALL, in S_CLEAR, latch clear_colour, write one pixel per cycle from address 0 to 19199, keep clear_busy=1 for exactly 19200 cycles, then enter S_IDLE.
REQ-020 SHALL accept a vga_plot write in S_IDLE and S_SCAN with 1-cycle write latency; it SHALL drop plots in S_CLEAR.
REQ-021 SHALL drop a plot with x>=160 or y>=120 (no write) and set plot_drop, which stays set until reset.
REQ-022 SHALL move S_IDLE->S_SCAN on scan_en=1 (with clear=0), with the scan counter at (0,0).
REQ-023 SHALL assert the first pix_valid 2 cycles after the cycle in which scan_en was sampled, to cover the synchronous RAM read latency.
REQ-024 SHALL follow valid/ready rules: a pixel transfers when pix_valid&&pix_ready; while pix_valid&&!pix_ready, every pix_* output SHALL stay stable.
REQ-025 SHALL sustain 1 pixel/cycle with pix_ready held at 1, with no bubbles inside a frame; a 2-entry output skid buffer absorbs backpressure.
REQ-026 SHALL emit pixels in raster order: x 0..159 wraps to 0 with y+1, and y 119 wraps to 0.
REQ-027 SHALL, after (159,119) is accepted, start a new frame at (0,0) if scan_en=1, else return to S_IDLE with pix_valid=0.
REQ-028 SHALL finish the current frame when scan_en deasserts mid-frame; frames are never truncated.
REQ-029 SHALL resolve a write and a scan read of the same address in the same cycle as read-first: the scan sees the old value, and the new value appears in the next frame.
REQ-030 SHALL keep pix_colour equal to the memory contents at the time of the read; out-of-range coordinates are never emitted.

Reset
REQ-031 SHALL, on rst_n=0, immediately (asynchronously) set state=S_IDLE, pix_valid=0, clear_busy=0, plot_drop=0, and pix_x/pix_y/pix_colour/pix_sof/pix_eol/pix_eof to 0, and empty the skid buffer and counters.
REQ-032 SHALL not reset memory contents, which are undefined until a clear or plot.
REQ-033 SHALL abort a fill or scan when reset is asserted mid-operation; after release the block is idle and no stale pixel is emitted.

Structure
REQ-034 SHALL place SCREEN_W=160, SCREEN_H=120, NPIX=19200, the colour_t (3-bit) and addr_t (15-bit) typedefs, and the state enum in package fb_pkg.
REQ-035 SHALL instantiate one sub-module, fb_ram: simple dual-port synchronous RAM with 1 write and 1 read port, 1-cycle read latency, read-first behaviour.

Verification
REQ-036 Bench SHALL cover reset: after rst_n 0->1, pix_valid=0, clear_busy=0, plot_drop=0, state=S_IDLE.
REQ-037 Bench SHALL cover clear then scan: clear=1 with clear_colour=3'b101 gives clear_busy high for exactly 19200 cycles; a following scan with pix_ready=1 gives 19200 pixels all 3'b101, pix_sof only at (0,0), pix_eol 120 times, pix_eof only at (159,119).
REQ-038 Bench SHALL cover plots: (0,0)=3'b010, (159,119)=3'b111, (160,5)=3'b001 give a scan showing 010 and 111 at those coordinates, (0,6) unchanged, and plot_drop=1.
REQ-039 Bench SHALL cover backpressure: pix_ready randomly toggled over a full frame gives exactly 19200 transfers, no loss or duplicates, and outputs stable during stalls.
REQ-040 Bench SHALL cover scan_en control: scan_en dropped at pixel (10,3) means the frame completes at (159,119), then S_IDLE; scan_en held continuously gives the next pixel after eof as (0,0) with pix_sof=1.
REQ-041 Bench SHALL cover collision and reset: a plot at the address being read in that cycle shows the old value this frame and the new value next frame; rst_n=0 mid-scan gives pix_valid=0 with no clock edge.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: screen geometry, pixel/address types and FSM states shared by the framebuffer.
package fb_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int NPIX     = SCREEN_W * SCREEN_H;

    typedef logic [2:0]  colour_t;
    typedef logic [14:0] addr_t;
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_CLEAR} state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        colour_t    c;
    } pix_t;

    function automatic addr_t pix_addr(input logic [7:0] x, input logic [6:0] y);
        return addr_t'(y) * addr_t'(SCREEN_W) + addr_t'(x);
    endfunction
endpackage

// File: rtl/fb_ram.sv
// fb_ram: simple dual-port synchronous pixel RAM, 1-cycle read latency, read-first on collision.
module fb_ram
    import fb_pkg::*;
(
    input  logic        clk,
    input  logic        i_we,
    input  logic [14:0] i_waddr,
    input  logic [2:0]  i_wdata,
    input  logic        i_re,
    input  logic [14:0] i_raddr,
    output logic [2:0]  o_rdata
);
    colour_t r_mem [NPIX];
    colour_t r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/plot_framebuffer.sv
// plot_framebuffer: 160x120x3 framebuffer with pixel plotting, full-screen fill and
// valid/ready raster scan-out through a one-deep read stage and a 2-entry skid buffer.
module plot_framebuffer
    import fb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] vga_x,
    input  logic [6:0] vga_y,
    input  logic [2:0] vga_colour,
    input  logic       vga_plot,
    input  logic       clear,
    input  logic [2:0] clear_colour,
    output logic       clear_busy,
    input  logic       scan_en,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic [7:0] pix_x,
    output logic [6:0] pix_y,
    output logic [2:0] pix_colour,
    output logic       pix_sof,
    output logic       pix_eol,
    output logic       pix_eof,
    output logic       plot_drop
);
    state_t     r_state;
    addr_t      r_clr_addr;
    colour_t    r_clr_colour;
    logic       r_clear_busy, r_plot_drop, r_more, r_rd_v, r_wp, r_rp;
    logic [7:0] r_sx, r_rd_x;
    logic [6:0] r_sy, r_rd_y;
    logic [1:0] r_cnt;
    pix_t       r_buf [2];

    logic       w_in_range, w_we, w_issue, w_pop, w_space, w_last_col, w_last_row;
    addr_t      w_waddr;
    colour_t    w_wdata, w_rdata;
    pix_t       w_head;

    assign w_in_range = (vga_x < 8'(SCREEN_W)) && (vga_y < 7'(SCREEN_H));
    assign w_we       = (r_state == S_CLEAR) || (vga_plot && w_in_range);
    assign w_waddr    = (r_state == S_CLEAR) ? r_clr_addr : pix_addr(vga_x, vga_y);
    assign w_wdata    = (r_state == S_CLEAR) ? r_clr_colour : vga_colour;

    assign w_head     = r_buf[r_rp];
    assign pix_valid  = r_cnt != 2'd0;
    assign pix_x      = w_head.x;
    assign pix_y      = w_head.y;
    assign pix_colour = w_head.c;
    assign pix_sof    = pix_valid && w_head.x == 8'd0 && w_head.y == 7'd0;
    assign pix_eol    = pix_valid && w_head.x == 8'(SCREEN_W - 1);
    assign pix_eof    = pix_eol && w_head.y == 7'(SCREEN_H - 1);
    assign clear_busy = r_clear_busy;
    assign plot_drop  = r_plot_drop;

    // A read is issued only if the in-flight read plus buffered pixels still fit after this cycle's pop.
    assign w_pop      = pix_valid && pix_ready;
    assign w_space    = ({1'b0, r_cnt} + {2'b0, r_rd_v}) < (3'd2 + {2'b0, w_pop});
    assign w_issue    = w_space && ((r_state == S_SCAN && r_more) || (r_state == S_IDLE && scan_en && !clear));
    assign w_last_col = r_sx == 8'(SCREEN_W - 1);
    assign w_last_row = r_sy == 7'(SCREEN_H - 1);

    fb_ram u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_issue),
        .i_raddr (pix_addr(r_sx, r_sy)),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_clr_addr   <= '0;
            r_clr_colour <= '0;
            r_clear_busy <= 1'b0;
            r_plot_drop  <= 1'b0;
            r_more       <= 1'b0;
            r_sx         <= '0;
            r_sy         <= '0;
            r_rd_v       <= 1'b0;
            r_rd_x       <= '0;
            r_rd_y       <= '0;
            r_wp         <= 1'b0;
            r_rp         <= 1'b0;
            r_cnt        <= '0;
            r_buf[0]     <= '0;
            r_buf[1]     <= '0;
        end else begin
            r_plot_drop <= r_plot_drop | (vga_plot & ~w_in_range);
            r_rd_v      <= w_issue;
            if (w_issue) begin
                r_rd_x <= r_sx;
                r_rd_y <= r_sy;
                r_sx   <= w_last_col ? '0 : r_sx + 8'd1;
                if (w_last_col) r_sy <= w_last_row ? '0 : r_sy + 7'd1;
            end
            if (r_rd_v) begin
                r_buf[r_wp] <= '{x: r_rd_x, y: r_rd_y, c: w_rdata};
                r_wp        <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, r_rd_v} - {1'b0, w_pop};
            case (r_state)
                S_IDLE: begin
                    if (clear) begin
                        r_state      <= S_CLEAR;
                        r_clear_busy <= 1'b1;
                        r_clr_addr   <= '0;
                        r_clr_colour <= clear_colour;
                    end else if (scan_en) begin
                        r_state <= S_SCAN;
                        r_more  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_addr == addr_t'(NPIX - 1)) begin
                        r_state      <= S_IDLE;
                        r_clear_busy <= 1'b0;
                    end else begin
                        r_clr_addr <= r_clr_addr + addr_t'(1);
                    end
                end
                S_SCAN: begin
                    if (w_issue && w_last_col && w_last_row) r_more <= 1'b0;
                    // Continue or stop is decided only once the frame's last pixel is taken.
                    if (w_pop && pix_eof) begin
                        if (scan_en) r_more <= 1'b1;
                        else         r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
